// File: rtl/regfile_pkg.sv
// Shared constants and types for the 32x64 register file.
// Default geometry, the zero-register index and the entry data type.
package regfile_pkg;

  localparam int RF_DATA_W   = 64;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 31;
  localparam int RF_ENTRIES  = 1 << RF_ADDR_W;

  typedef logic [RF_DATA_W-1:0] rf_data_t;
  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

endpackage

// File: rtl/dec1to2.sv
// 1-to-2 decoder with enable; building block of the write decode tree.
// Ports: en_i enable, a_i select bit, y_o[1:0] one-hot (all 0 when disabled).
module dec1to2 (
  input  logic       en_i,
  input  logic       a_i,
  output logic [1:0] y_o
);

  assign y_o[0] = en_i & ~a_i;
  assign y_o[1] = en_i &  a_i;

endmodule

// File: rtl/decode_5_32.sv
// 5-to-32 one-hot decoder with enable, a tree of dec1to2 cells, MSB first.
// Ports: idx_i[4:0] index, en_i enable, onehot_o[31:0] one-hot enables.
module decode_5_32
  import regfile_pkg::*;
(
  input  logic [4:0]  idx_i,
  input  logic        en_i,
  output logic [31:0] onehot_o
);

  logic [1:0]  l0;
  logic [3:0]  l1;
  logic [7:0]  l2;
  logic [15:0] l3;

  // Output bit 2n+b of a level means "prefix n, then bit b", so the
  // final vector is indexed by the binary value of idx_i.
  dec1to2 u_l0 (
    .en_i (en_i),
    .a_i  (idx_i[4]),
    .y_o  (l0)
  );

  for (genvar n = 0; n < 2; n++) begin : g_l1
    dec1to2 u_d (
      .en_i (l0[n]),
      .a_i  (idx_i[3]),
      .y_o  (l1[2*n+1:2*n])
    );
  end

  for (genvar n = 0; n < 4; n++) begin : g_l2
    dec1to2 u_d (
      .en_i (l1[n]),
      .a_i  (idx_i[2]),
      .y_o  (l2[2*n+1:2*n])
    );
  end

  for (genvar n = 0; n < 8; n++) begin : g_l3
    dec1to2 u_d (
      .en_i (l2[n]),
      .a_i  (idx_i[1]),
      .y_o  (l3[2*n+1:2*n])
    );
  end

  for (genvar n = 0; n < RF_ENTRIES / 2; n++) begin : g_l4
    dec1to2 u_d (
      .en_i (l3[n]),
      .a_i  (idx_i[0]),
      .y_o  (onehot_o[2*n+1:2*n])
    );
  end

endmodule

// File: rtl/regfile_32x64.sv
// 2**ADDR_W x DATA_W register file: one write port, two combinational reads.
// Ports: clk, reset (async, active-high); RegWrite/WriteRegister/WriteData
// write port; ReadRegister1/2 -> ReadData1/2. Entry ZERO_REG reads 0.
// Macro REGFILE_WRITE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_32x64
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = RF_ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int NENT = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(ZERO_REG);

  logic              wen;
  logic [NENT-1:0]   we;
  logic [DATA_W-1:0] rf [NENT];

  // Writes to the zero register never reach the decoder.
  assign wen = RegWrite & (WriteRegister != ZIDX);

  if (ADDR_W == 5) begin : g_dec5
    decode_5_32 u_dec (
      .idx_i    (WriteRegister),
      .en_i     (wen),
      .onehot_o (we)
    );
  end else begin : g_decn
    assign we = wen ? ({{(NENT-1){1'b0}}, 1'b1} << WriteRegister)
                    : '0;
  end

  for (genvar i = 0; i < NENT; i++) begin : g_ent
    if (i == ZERO_REG) begin : g_zero
      logic unused_zero_we;
      assign unused_zero_we = we[i];
      assign rf[i] = '0;
    end else begin : g_reg
      logic [DATA_W-1:0] entry_q;
      logic [DATA_W-1:0] entry_d;

      assign entry_d = we[i] ? WriteData : entry_q;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          entry_q <= '0;
        end else begin
          entry_q <= entry_d;
        end
      end

      assign rf[i] = entry_q;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Gated by reset so reads stay 0 while reset is held.
  assign byp1 = wen & ~reset & (ReadRegister1 == WriteRegister);
  assign byp2 = wen & ~reset & (ReadRegister2 == WriteRegister);

  always_comb begin
    ReadData1 = rf[ReadRegister1];
    ReadData2 = rf[ReadRegister2];
    if (byp1) ReadData1 = WriteData;
    if (byp2) ReadData2 = WriteData;
  end
`else
  always_comb begin
    ReadData1 = rf[ReadRegister1];
    ReadData2 = rf[ReadRegister2];
  end
`endif

endmodule

// File: tb/tb_regfile_32x64.sv
// Self-checking bench for regfile_32x64: array model + directed vectors.
// Honours REGFILE_WRITE_BYPASS_EN for same-cycle read expectations.
module tb_regfile_32x64;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        RegWrite = 1'b0;
  logic [4:0]  WriteRegister = '0;
  logic [63:0] WriteData = '0;
  logic [4:0]  ReadRegister1 = '0;
  logic [4:0]  ReadRegister2 = '0;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int errors = 0;
  int checks = 0;
  logic cmp_en = 1'b0;

  rf_data_t model [32];

  regfile_32x64 dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 32; k++) model[k] <= '0;
    end else if (RegWrite && WriteRegister != 5'd31) begin
      model[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [63:0] exp_rd(input logic [4:0] a);
    if (a == 5'd31) return 64'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!reset && RegWrite && a == WriteRegister) return WriteData;
`endif
    return model[a];
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_rd1", ReadData1, exp_rd(ReadRegister1));
      chk("cyc_rd2", ReadData2, exp_rd(ReadRegister2));
    end
  end

  task automatic wr(input logic [4:0] a, input logic [63:0] d);
    RegWrite = 1'b1;
    WriteRegister = a;
    WriteData = d;
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd0;
    #1;
    chk("reset_rd1", ReadData1, 64'h0);
    chk("reset_rd2", ReadData2, 64'h0);

    // Release and write on the very first edge afterwards.
    reset = 1'b0;
    ReadRegister1 = 5'd3;
    ReadRegister2 = 5'd4;
    wr(5'd3, 64'h0123_4567_89AB_CDEF);
    chk("wr3_rd1", ReadData1, 64'h0123_4567_89AB_CDEF);
    chk("wr4_rd2", ReadData2, 64'h0);

    // Zero register, same cycle and after the edge.
    ReadRegister1 = 5'd31;
    ReadRegister2 = 5'd31;
    RegWrite = 1'b1;
    WriteRegister = 5'd31;
    WriteData = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("z_same_rd1", ReadData1, 64'h0);
    chk("z_same_rd2", ReadData2, 64'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("z_after_rd1", ReadData1, 64'h0);
    chk("z_after_rd2", ReadData2, 64'h0);

    // Disabled write keeps the prior value.
    wr(5'd7, 64'h11);
    ReadRegister1 = 5'd7;
    WriteRegister = 5'd7;
    WriteData = 64'h55;
    repeat (3) @(posedge clk);
    #1;
    chk("nowr_rd1", ReadData1, 64'h11);

    // Same-cycle read of the entry being written.
    wr(5'd9, 64'h1);
    ReadRegister1 = 5'd9;
    RegWrite = 1'b1;
    WriteRegister = 5'd9;
    WriteData = 64'h2;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("haz_pre", ReadData1, 64'h2);
`else
    chk("haz_pre", ReadData1, 64'h1);
`endif
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    chk("haz_post", ReadData1, 64'h2);
    ReadRegister2 = 5'd9;
    #1;
    chk("same_rd1", ReadData1, 64'h2);
    chk("same_rd2", ReadData2, 64'h2);

    // Sweep every entry through both ports.
    for (int i = 0; i < 31; i++) wr(5'(i), 64'(i) * 64'h0101);
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #1;
      chk("sw_rd1", ReadData1,
          (i == 31) ? 64'h0 : 64'(i) * 64'h0101);
      chk("sw_rd2", ReadData2,
          (i == 0) ? 64'h0 : 64'(31 - i) * 64'h0101);
      @(posedge clk);
      #1;
    end

    // Mid-cycle asynchronous reset clears before the next edge.
    wr(5'd5, 64'hDEAD);
    ReadRegister1 = 5'd5;
    ReadRegister2 = 5'd3;
    #1;
    chk("pre_rst_rd1", ReadData1, 64'hDEAD);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_rd1", ReadData1, 64'h0);
    chk("mid_rst_rd2", ReadData2, 64'h0);

    // Write edge while reset is held is ignored.
    RegWrite = 1'b1;
    WriteRegister = 5'd6;
    WriteData = 64'hAA;
    ReadRegister1 = 5'd6;
    @(posedge clk);
    #1;
    chk("rst_wr_rd1", ReadData1, 64'h0);
    RegWrite = 1'b0;
    reset = 1'b0;
    #1;
    chk("post_rst_rd1", ReadData1, 64'h0);
    chk("post_rst_rd2", ReadData2, 64'h0);
    wr(5'd6, 64'hBEEF);
    chk("post_rst_wr", ReadData1, 64'hBEEF);

    @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_32x64.md
REGFILE_32X64 -- requirements
Module: regfile_32x64

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, register width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width (2**ADDR_W entries).
REQ-003 SHALL provide parameter ZERO_REG, default 31, index of the hard-wired zero register.
REQ-004 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL provide port RegWrite  input  1  write enable from the write-back stage.
REQ-007 SHALL provide port WriteRegister  input  ADDR_W  destination register index.
REQ-008 SHALL provide port WriteData  input  DATA_W  write-back value.
REQ-009 SHALL provide port ReadRegister1  input  ADDR_W  source index, port A.
REQ-010 SHALL provide port ReadRegister2  input  ADDR_W  source index, port B.
REQ-011 SHALL provide port ReadData1  output  DATA_W  port A read value.
REQ-012 SHALL provide port ReadData2  output  DATA_W  port B read value.

Function
REQ-013 SHALL hold 2**ADDR_W registers of DATA_W bits, one write port and two independent read ports.
REQ-014 SHALL write WriteData into entry WriteRegister on the rising clk edge when RegWrite=1 and reset=0; no other entry changes.
REQ-015 SHALL leave every entry unchanged on a clock edge with RegWrite=0.
REQ-016 SHALL derive per-entry write enables with a one-hot decode of WriteRegister gated by RegWrite; at most one enable active per cycle.
REQ-017 SHALL produce ReadData1/ReadData2 combinationally from the addressed entries (zero-cycle read latency, no clock involved).
REQ-018 SHALL return 0 on any read of ZERO_REG, regardless of prior writes.
REQ-019 SHALL discard writes to ZERO_REG (entry stays 0; no bypass of that data).
REQ-020 SHALL permit both read ports to address the same entry simultaneously with identical results.
REQ-021 SHALL, for a read of the entry being written in the same cycle, follow the Configuration section.

Reset
REQ-022 SHALL clear every entry to 0 immediately on reset assertion, without waiting for clk.
REQ-023 SHALL give reset priority over a coincident write; a write edge while reset=1 is ignored.
REQ-024 SHALL drive ReadData1=ReadData2=0 while reset=1 and after release until a write occurs.
REQ-025 SHALL accept writes from the first rising clk edge after reset deasserts.

Configuration
REQ-026 SHALL recognise macro REGFILE_WRITE_BYPASS_EN.
REQ-027 With REGFILE_WRITE_BYPASS_EN defined, a read port whose index equals WriteRegister while RegWrite=1 and index!=ZERO_REG SHALL output WriteData combinationally in that same cycle.
REQ-028 Without REGFILE_WRITE_BYPASS_EN, such a read SHALL output the stored (old) value until the write edge, then the new value.

Structure
REQ-029 SHALL place DATA_W/ADDR_W/ZERO_REG defaults and a regfile data typedef in shared package regfile_pkg.
REQ-030 SHALL implement the write-enable decode as sub-module decode_5_32 (input 5-bit index, enable; output 32-bit one-hot), built hierarchically from the team's 1-to-2 enable decoders.
REQ-031 SHALL contain no latches; all storage is edge-triggered flip-flops with async reset.

Verification
REQ-032 Reset: assert reset mid-cycle after writing X5=64'hDEAD -> ReadData1 (addr 5) reads 0 before the next clk edge.
REQ-033 Write/read: RegWrite=1, WriteRegister=3, WriteData=64'h0123_4567_89AB_CDEF, edge -> ReadRegister1=3 gives that value; ReadRegister2=4 gives 0.
REQ-034 Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to 31 -> ReadData1/ReadData2 at 31 read 0, including same cycle.
REQ-035 Disabled write: RegWrite=0, WriteRegister=7, WriteData=64'h55 over 3 edges -> entry 7 stays at prior value 64'h11.
REQ-036 Same-cycle hazard: entry 9=64'h1, write 64'h2 to 9 with ReadRegister1=9 -> pre-edge output 64'h2 with REGFILE_WRITE_BYPASS_EN, 64'h1 without; 64'h2 after edge in both builds.
REQ-037 Sweep: write i*64'h0101 to entries 0..30, then read all via both ports -> every value matches, entry 31 reads 0.
